// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited request stream to instruction memory,
// in-order response buffer, and redirect handling that drains stale responses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam int          CNT_W      = PTR_W + 1;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        buf_data_q [FIFO_DEPTH];
  logic [31:0]        buf_pc_q   [FIFO_DEPTH];

  logic credit_ok, req_fire, rsp_live, push, pop;

  // Credit rule: every request in flight already owns a buffer slot.
  assign credit_ok     = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign mem_req_valid = (state_q == RUN) && credit_ok && !redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_live      = mem_rsp_valid && (outstanding_q != '0);
  assign push          = rsp_live && (state_q == RUN) && !redirect_valid;

  assign instr_valid   = (count_q != '0);
  assign pop           = instr_valid && instr_ready;
  assign instr_data    = instr_valid ? buf_data_q[head_q] : '0;
  assign instr_pc      = instr_valid ? buf_pc_q[head_q]   : '0;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;

    case (state_q)
      BOOT: state_d = RUN;
      RUN, DRAIN: begin
        if (redirect_valid) begin
          // Requests still in flight belong to the old path; a response
          // landing this cycle is already accounted for and discarded.
          fetch_pc_d    = redirect_pc & ~32'h3;
          rsp_pc_d      = redirect_pc & ~32'h3;
          count_d       = '0;
          head_d        = '0;
          tail_d        = '0;
          outstanding_d = outstanding_q - CNT_W'(rsp_live);
          drop_cnt_d    = outstanding_q - CNT_W'(rsp_live);
          state_d       = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
          if (state_q == RUN) begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push) begin
              tail_d   = tail_q + PTR_W'(1);
              rsp_pc_d = rsp_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
          end else begin
            if (rsp_live) begin
              outstanding_d = outstanding_q - CNT_W'(1);
              drop_cnt_d    = drop_cnt_q - CNT_W'(1);
            end
            if (drop_cnt_d == '0) state_d = RUN;
          end
          if (pop) head_d = head_q + PTR_W'(1);
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC_A;
      rsp_pc_q      <= RESET_PC_A;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // NOTE: buffer storage has no reset; count_q gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[tail_q] <= mem_rsp_data;
      buf_pc_q[tail_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model with epoch tags
// and an expected-instruction scoreboard checked at every core handshake.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          epoch    = 0;
  bit          mem_en   = 1'b1;
  logic [31:0] pend_addr [$];
  int          pend_epoch[$];
  exp_t        exp_q     [$];
  logic [31:0] req_log   [$];
  logic [31:0] exp_req_addr = RESET_PC;
  logic        s_req_valid, s_instr_valid;
  logic [31:0] s_req_addr;
  int          n_pops = 0;
  bit          got_pop = 1'b0;
  logic [31:0] first_pop_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle, entered and left at posedge+1 with inputs already set.
  task automatic cycle();
    logic [31:0] a;
    int          e;
    exp_t        x;
    if (rst && redirect_valid) epoch++;
    if (mem_en && pend_addr.size() > 0) begin
      a = pend_addr.pop_front();
      e = pend_epoch.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(a);
      if (e == epoch) exp_q.push_back('{pc: a, data: mem_word(a)});
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    @(negedge clk);
    s_req_valid   = mem_req_valid;
    s_req_addr    = mem_req_addr;
    s_instr_valid = instr_valid;
    if (rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        check("instr_spurious", {31'b0, instr_valid}, 32'd0);
      end else begin
        x = exp_q.pop_front();
        check("instr_pc", instr_pc, x.pc);
        check("instr_data", instr_data, x.data);
        n_pops++;
        if (!got_pop) first_pop_pc = instr_pc;
        got_pop = 1'b1;
      end
    end
    if (rst && mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_req_addr);
      req_log.push_back(mem_req_addr);
      pend_addr.push_back(mem_req_addr);
      pend_epoch.push_back(epoch);
      exp_req_addr = mem_req_addr + 32'd4;
    end
    if (rst && redirect_valid) begin
      exp_q.delete();
      exp_req_addr = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input bit keep_pending);
    if (!keep_pending) begin
      pend_addr.delete();
      pend_epoch.delete();
    end
    epoch++;
    exp_q.delete();
    exp_req_addr   = RESET_PC;
    redirect_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_req_addr", mem_req_addr, RESET_PC);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    cycle();
    rst = 1'b1;
    cycle();
    check("boot_no_req", {31'b0, s_req_valid}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a0;
    #1;

    // Streaming fetch from reset, then a stall with the request held.
    do_reset(1'b0);
    req_log.delete();
    got_pop = 1'b0;
    n_pops  = 0;
    run(20);
    check("stream_pops", {31'b0, n_pops >= 5}, 32'd1);
    check("stream_first_pc", first_pop_pc, RESET_PC);
    if (req_log.size() >= 3) begin
      check("stream_req0", req_log[0], 32'h0);
      check("stream_req1", req_log[1], 32'h4);
      check("stream_req2", req_log[2], 32'h8);
    end else check("stream_req_count", req_log.size(), 32'd3);
    mem_req_ready = 1'b0;
    run(3);
    a0 = s_req_addr;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_valid", {31'b0, s_req_valid}, 32'd1);
      check("stall_addr", s_req_addr, a0);
    end
    mem_req_ready = 1'b1;
    run(6);

    // Core stalled: only FIFO_DEPTH requests, then resume at 0x8.
    instr_ready = 1'b0;
    do_reset(1'b0);
    req_log.delete();
    run(8);
    check("full_req_count", req_log.size(), 32'd2);
    check("full_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("full_instr_valid", {31'b0, s_instr_valid}, 32'd1);
    instr_ready = 1'b1;
    req_log.delete();
    got_pop = 1'b0;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    check("resume_req_seen", {31'b0, req_log.size() > 0}, 32'd1);
    if (req_log.size() > 0) check("resume_addr", req_log[0], 32'h8);
    check("resume_first_pc", first_pop_pc, 32'h0);
    run(6);

    // Redirect with two requests in flight: both responses dropped.
    mem_en = 1'b0;
    do_reset(1'b0);
    req_log.delete();
    run(3);
    check("redir_outstanding", req_log.size(), 32'd2);
    redirect(32'h0000_0100);
    mem_en  = 1'b1;
    got_pop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("drain_instr_valid", {31'b0, s_instr_valid}, 32'd0);
      check("drain_req_valid", {31'b0, s_req_valid}, 32'd0);
    end
    for (int i = 0; i < 12 && !got_pop; i++) cycle();
    check("redir_pop_seen", {31'b0, got_pop}, 32'd1);
    check("redir_first_pc", first_pop_pc, 32'h0000_0100);

    // Unaligned target and address wrap.
    req_log.delete();
    redirect(32'h0000_0103);
    for (int i = 0; i < 10 && req_log.size() < 1; i++) cycle();
    check("align_req_seen", {31'b0, req_log.size() >= 1}, 32'd1);
    if (req_log.size() >= 1) check("align_addr", req_log[0], 32'h0000_0100);
    req_log.delete();
    got_pop = 1'b0;
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 12 && req_log.size() < 2; i++) cycle();
    check("wrap_req_seen", {31'b0, req_log.size() >= 2}, 32'd1);
    if (req_log.size() >= 2) begin
      check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_req1", req_log[1], 32'h0000_0000);
    end
    run(6);
    check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);

    // Redirect coinciding with a response and an instruction handshake.
    instr_ready = 1'b0;
    mem_en      = 1'b0;
    do_reset(1'b0);
    run(3);
    mem_en = 1'b1;
    cycle();
    instr_ready = 1'b1;
    got_pop     = 1'b0;
    redirect(32'h0000_0200);
    check("same_cycle_pop", {31'b0, got_pop}, 32'd1);
    check("same_cycle_pop_pc", first_pop_pc, 32'h0);
    cycle();
    check("same_cycle_empty", {31'b0, s_instr_valid}, 32'd0);
    check("same_cycle_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("same_cycle_req_addr", s_req_addr, 32'h0000_0200);
    run(8);

    // Reset pulsed with two requests in flight; late responses ignored.
    mem_en = 1'b0;
    do_reset(1'b0);
    run(3);
    mem_en = 1'b1;
    do_reset(1'b1);
    got_pop = 1'b0;
    req_log.delete();
    for (int i = 0; i < 12 && !got_pop; i++) cycle();
    check("post_rst_pop_seen", {31'b0, got_pop}, 32'd1);
    check("post_rst_first_pc", first_pop_pc, RESET_PC);
    if (req_log.size() > 0) check("post_rst_req0", req_log[0], RESET_PC);
    else check("post_rst_req_seen", req_log.size(), 32'd1);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
